// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: receiver-to-parser byte stream and parser-to-PID configuration bundle
// master: receiver side, drives clk_en (16x tick), rx_byte, rx_rdy (ready level)
// slave: parser side, drives kp/ki/kd/setpoint, cfg_wr/cfg_addr pulse, frame_err pulse, err_cnt
interface uart_cmd_parser_if;
  logic clk_en;
  logic [7:0] rx_byte;
  logic rx_rdy;
  logic [15:0] kp, ki, kd, setpoint;
  logic cfg_wr;
  logic [1:0] cfg_addr;
  logic frame_err;
  logic [7:0] err_cnt;
  modport master (output clk_en, rx_byte, rx_rdy, input kp, ki, kd, setpoint, cfg_wr, cfg_addr, frame_err, err_cnt);
  modport slave (input clk_en, rx_byte, rx_rdy, output kp, ki, kd, setpoint, cfg_wr, cfg_addr, frame_err, err_cnt);
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte HEADER/ADDR/DHI/DLO/CHK frames into 16-bit PID config writes
// clk_in: system clock; reset: synchronous active-low
// bus (slave): rx side clk_en/rx_byte/rx_rdy in; kp/ki/kd/setpoint, cfg_wr/cfg_addr, frame_err, err_cnt out
module uart_cmd_parser #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int TIMEOUT_TICKS = 640,
  parameter logic [15:0] KP_INIT = 16'h0100,
  parameter logic [15:0] KI_INIT = 16'h0000,
  parameter logic [15:0] KD_INIT = 16'h0000,
  parameter logic [15:0] SP_INIT = 16'h0000
) (
  input logic clk_in,
  input logic reset,
  uart_cmd_parser_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [2:0] {IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, COMMIT} state_t;
  state_t state_q, state_d;
  logic rdy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d, hi_q, hi_d, lo_q, lo_d;
  logic [15:0] regs_q [4];
  logic cfg_wr_q, frame_err_q, err_d;
  logic [1:0] cfg_addr_q;
  logic [7:0] err_cnt_q;
  logic acc, in_frame, tmo, chk_ok;
  assign acc = bus.rx_rdy & ~rdy_q;
  assign in_frame = state_q inside {S_ADDR, S_DHI, S_DLO, S_CHK};
  // an accepted byte on the expiry tick takes precedence over the timeout
  assign tmo = in_frame & ~acc & bus.clk_en & (cnt_q == CW'(TIMEOUT_TICKS - 1));
  assign chk_ok = (bus.rx_byte == (addr_q ^ hi_q ^ lo_q)) && (addr_q[7:2] == 6'd0);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    hi_d = hi_q;
    lo_d = lo_q;
    err_d = 1'b0;
    cnt_d = (!in_frame || acc || tmo) ? '0 : cnt_q + CW'(bus.clk_en);
    case (state_q)
      IDLE: state_d = (acc && bus.rx_byte == HEADER) ? S_ADDR : IDLE;
      S_ADDR: if (acc) begin
        addr_d = bus.rx_byte;
        state_d = S_DHI;
      end
      S_DHI: if (acc) begin
        hi_d = bus.rx_byte;
        state_d = S_DLO;
      end
      S_DLO: if (acc) begin
        lo_d = bus.rx_byte;
        state_d = S_CHK;
      end
      S_CHK: if (acc) begin
        state_d = chk_ok ? COMMIT : IDLE;
        err_d = ~chk_ok;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      regs_q <= '{KP_INIT, KI_INIT, KD_INIT, SP_INIT};
      cfg_wr_q <= 1'b0;
      cfg_addr_q <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= bus.rx_rdy;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (state_q == COMMIT) regs_q[addr_q[1:0]] <= {hi_q, lo_q};
      cfg_wr_q <= state_q == COMMIT;
      cfg_addr_q <= (state_q == COMMIT) ? addr_q[1:0] : cfg_addr_q;
      frame_err_q <= err_d;
      err_cnt_q <= err_cnt_q + 8'(err_d && err_cnt_q != 8'hFF);
    end
  end
  assign bus.kp = regs_q[0];
  assign bus.ki = regs_q[1];
  assign bus.kd = regs_q[2];
  assign bus.setpoint = regs_q[3];
  assign bus.cfg_wr = cfg_wr_q;
  assign bus.cfg_addr = cfg_addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized and directed frames against a frame-buffer reference model
module tb_uart_cmd_parser;
  logic clk_in = 1'b0;
  logic reset = 1'b0;
  uart_cmd_parser_if bus();
  uart_cmd_parser dut (.clk_in(clk_in), .reset(reset), .bus(bus));
  always #5 clk_in = ~clk_in;
  int total = 0, bad = 0;
  bit armed = 1'b0, en_rand = 1'b0;
  logic [15:0] m_reg [4];
  logic m_wr, m_err, prev, pend, acc;
  logic [1:0] m_addr, pa;
  logic [15:0] pv;
  logic [7:0] m_cnt;
  logic [7:0] fb [5];
  int pos, ticks;
  always @(posedge clk_in) begin
    if (!reset) begin
      m_reg = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
      m_wr = 0; m_err = 0; m_addr = 0; m_cnt = 0;
      pos = 0; ticks = 0; prev = 0; pend = 0;
    end else begin
      acc = bus.rx_rdy && !prev;
      prev = bus.rx_rdy;
      m_wr = 0; m_err = 0;
      if (pend) begin
        m_reg[pa] = pv; m_wr = 1; m_addr = pa; pend = 0;
      end else if (pos == 0) begin
        if (acc && bus.rx_byte == 8'hA5) begin pos = 1; ticks = 0; end
      end else if (acc) begin
        fb[pos] = bus.rx_byte; pos++; ticks = 0;
        if (pos == 5) begin
          pos = 0;
          if (fb[4] == (fb[1] ^ fb[2] ^ fb[3]) && fb[1] < 8'd4) begin
            pend = 1; pa = fb[1][1:0]; pv = {fb[2], fb[3]};
          end else m_err = 1;
        end
      end else if (bus.clk_en) begin
        ticks++;
        if (ticks == 640) begin pos = 0; m_err = 1; end
      end
      if (m_err && m_cnt != 8'hFF) m_cnt++;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk_in) if (armed) begin
    chk("kp", 32'(bus.kp), 32'(m_reg[0]));
    chk("ki", 32'(bus.ki), 32'(m_reg[1]));
    chk("kd", 32'(bus.kd), 32'(m_reg[2]));
    chk("setpoint", 32'(bus.setpoint), 32'(m_reg[3]));
    chk("cfg_wr", 32'(bus.cfg_wr), 32'(m_wr));
    chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
    if (m_wr) chk("cfg_addr", 32'(bus.cfg_addr), 32'(m_addr));
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      bus.clk_en = en_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  endtask
  // wk/ek: first cycle (1 = edge that accepts the byte) showing cfg_wr/frame_err
  task automatic send_watch(input logic [7:0] b, input int hi, input int gap, output int wk, output int ek,
                            output logic [1:0] wa, output int nw, output int ne);
    wk = -1; ek = -1; wa = 0; nw = 0; ne = 0;
    bus.rx_byte = b;
    bus.rx_rdy = 1'b1;
    for (int k = 1; k <= hi + gap; k++) begin
      tick(1);
      if (k == hi) begin bus.rx_rdy = 1'b0; bus.rx_byte = 8'($urandom); end
      if (bus.cfg_wr) begin nw++; if (wk < 0) begin wk = k; wa = bus.cfg_addr; end end
      if (bus.frame_err) begin ne++; if (ek < 0) ek = k; end
    end
  endtask
  task automatic send5(input logic [39:0] f, input int hi, input int gap, output int wk, output int ek,
                       output logic [1:0] wa, output int nw, output int ne);
    int a, b;
    nw = 0; ne = 0;
    for (int i = 0; i < 5; i++) begin
      send_watch(f[39-8*i -: 8], hi, gap, wk, ek, wa, a, b);
      nw += a; ne += b;
    end
  endtask
  initial begin
    int wk, ek, nw, ne, sw;
    logic [1:0] wa;
    logic [7:0] ad, dh, dl, ck, jb;
    bus.clk_en = 0; bus.rx_byte = 0; bus.rx_rdy = 0;
    tick(3);
    armed = 1;
    tick(1);
    reset = 1;
    tick(5);
    chk("rst_kp", 32'(bus.kp), 32'h0100);
    chk("rst_ki", 32'(bus.ki), 0);
    chk("rst_kd", 32'(bus.kd), 0);
    chk("rst_sp", 32'(bus.setpoint), 0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
    chk("rst_pulses", 32'({bus.cfg_wr, bus.frame_err}), 0);
    send5(40'hA5_01_12_34_27, 16, 4, wk, ek, wa, nw, ne);
    chk("ki_latency", wk, 2);
    chk("ki_wr_count", nw, 1);
    chk("ki_wr_addr", 32'(wa), 1);
    chk("ki_value", 32'(bus.ki), 32'h1234);
    chk("ki_kp_kept", 32'(bus.kp), 32'h0100);
    send5(40'hA5_02_12_34_00, 4, 2, wk, ek, wa, nw, ne);
    chk("badchk_err_cycle", ek, 1);
    chk("badchk_err_count", ne, 1);
    chk("badchk_no_wr", nw, 0);
    chk("badchk_err_cnt", 32'(bus.err_cnt), 1);
    chk("badchk_kd", 32'(bus.kd), 0);
    send5(40'hA5_02_00_05_07, 4, 2, wk, ek, wa, nw, ne);
    chk("kd_value", 32'(bus.kd), 32'h0005);
    send_watch(8'h55, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'hA5, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'h03, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'hFF, 4, 700, wk, ek, wa, nw, ne);
    chk("tmo_cycle", ek, 641);
    chk("tmo_count", ne, 1);
    chk("tmo_err_cnt", 32'(bus.err_cnt), 2);
    chk("tmo_sp", 32'(bus.setpoint), 0);
    send_watch(8'hA5, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'h03, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'hFF, 4, 636, wk, ek, wa, nw, ne);
    chk("edge_no_tmo", ne, 0);
    send_watch(8'h00, 4, 2, wk, ek, wa, nw, ne);
    chk("edge_byte_wins", ne, 0);
    send_watch(8'hFC, 4, 2, wk, ek, wa, nw, ne);
    chk("edge_wr_cycle", wk, 2);
    chk("edge_sp", 32'(bus.setpoint), 32'hFF00);
    chk("edge_err_cnt", 32'(bus.err_cnt), 2);
    send5(40'hA5_04_00_00_04, 4, 2, wk, ek, wa, nw, ne);
    chk("oor_err", ne, 1);
    chk("oor_no_wr", nw, 0);
    chk("oor_err_cnt", 32'(bus.err_cnt), 3);
    en_rand = 1;
    for (int i = 0; i < 60; i++) begin
      int r, hi, gap;
      r = $urandom_range(0, 5);
      hi = $urandom_range(2, 6);
      gap = $urandom_range(1, 4);
      ad = 8'($urandom_range(0, 3)); dh = 8'($urandom); dl = 8'($urandom);
      if (r == 4) ad = {6'($urandom_range(1, 63)), 2'($urandom)};
      ck = ad ^ dh ^ dl;
      if (r == 3) ck = ck ^ 8'($urandom_range(1, 255));
      if (r == 5) begin
        send_watch(8'hA5, hi, gap, wk, ek, wa, nw, ne);
        repeat ($urandom_range(0, 3)) send_watch(8'($urandom), hi, gap, wk, ek, wa, nw, ne);
        tick(1600);
      end else send5({8'hA5, ad, dh, dl, ck}, hi, gap, wk, ek, wa, nw, ne);
      if ($urandom_range(0, 2) == 0) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_watch(jb, hi, gap, wk, ek, wa, nw, ne);
      end
    end
    en_rand = 0;
    sw = 0;
    repeat (300) begin
      send5(40'hA5_04_00_00_04, 2, 1, wk, ek, wa, nw, ne);
      sw += nw;
    end
    chk("sat_err_cnt", 32'(bus.err_cnt), 255);
    chk("sat_no_wr", sw, 0);
    send_watch(8'hA5, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'h00, 4, 2, wk, ek, wa, nw, ne);
    send_watch(8'hAB, 4, 2, wk, ek, wa, nw, ne);
    reset = 0;
    tick(2);
    reset = 1;
    tick(2);
    chk("midrst_kp", 32'(bus.kp), 32'h0100);
    chk("midrst_err_cnt", 32'(bus.err_cnt), 0);
    sw = 0;
    send_watch(8'h00, 4, 2, wk, ek, wa, nw, ne); sw += nw + ne;
    send_watch(8'hCD, 4, 2, wk, ek, wa, nw, ne); sw += nw + ne;
    send_watch(8'h61, 4, 2, wk, ek, wa, nw, ne); sw += nw + ne;
    chk("midrst_no_pulse", sw, 0);
    chk("midrst_kp_kept", 32'(bus.kp), 32'h0100);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
